// File: rtl/stream_line_packer_pkg.sv
// Shared constants, state encoding and address helper for the stream line packer.
package stream_line_packer_pkg;

    localparam int WORD_W      = 32;
    localparam int LINE_WORDS  = 16;
    localparam int ADDR_W      = 9;
    localparam int CNT_W       = 10;
    localparam int LINE_W      = WORD_W * LINE_WORDS;
    localparam int LINE_STRIDE = 16;
    localparam int IDX_W       = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Snap an arbitrary word address down to the start of its line.
    function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_STRIDE - 1);
    endfunction

endpackage

// File: rtl/stream_line_packer_line_buffer.sv
// Line assembly register: one word slot written per accept, whole line cleared at once.
module stream_line_packer_line_buffer
    import stream_line_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    output logic [LINE_W-1:0] line_data
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (clr) begin
            line_q <= '0;
        end else if (wr_en) begin
            line_q[wr_idx*WORD_W +: WORD_W] <= wr_data;
        end
    end

    assign line_data = line_q;

endmodule

// File: rtl/stream_line_packer.sv
// Packs a valid/ready stream of 32-bit words into 512-bit lines and issues one
// single-cycle write per line at a line-aligned, auto-incrementing address.
module stream_line_packer
    import stream_line_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_input_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_written,
    output logic [1:0]        state_dbg
);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is registered and high only while in FILL.
    state_t           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q;
    logic             last_flag_q;
    logic             accept;
    logic             session_start;
    logic             buf_clr;

    assign accept        = in_valid & in_ready;
    assign session_start = (state_q == IDLE) && start;
    assign buf_clr       = session_start || (state_q == WRITE);
    assign state_dbg     = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = FILL;
            FILL:  if (accept && ((word_idx_q == IDX_W'(LINE_WORDS - 1)) || in_last)) state_d = WRITE;
            WRITE: state_d = last_flag_q ? DONE : FILL;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change only on the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            in_ready      <= 1'b0;
            mem_write_en  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_address   <= '0;
            lines_written <= '0;
            word_idx_q    <= '0;
            last_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready     <= (state_d == FILL);
            mem_write_en <= (state_d == WRITE);
            busy         <= (state_d != IDLE);
            done         <= (state_d == DONE);

            if (session_start) begin
                mem_address   <= align_line(start_addr);
                lines_written <= '0;
                word_idx_q    <= '0;
                last_flag_q   <= 1'b0;
            end

            if (accept) begin
                word_idx_q  <= word_idx_q + IDX_W'(1);
                last_flag_q <= in_last;
            end

            // Address wraps naturally at the top of the 512-word memory.
            if (state_q == WRITE) begin
                mem_address   <= mem_address + ADDR_W'(LINE_STRIDE);
                lines_written <= lines_written + CNT_W'(1);
                word_idx_q    <= '0;
            end
        end
    end

    stream_line_packer_line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr       (buf_clr),
        .wr_en     (accept),
        .wr_idx    (word_idx_q),
        .wr_data   (in_data),
        .line_data (mem_input_data)
    );

endmodule

// File: tb/tb_stream_line_packer.sv
// Bench for stream_line_packer: session table plus hand-written corner sequences,
// with a line scoreboard fed by a reference packing model.
module tb_stream_line_packer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [8:0]   start_addr;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         mem_write_en;
    logic [8:0]   mem_address;
    logic [511:0] mem_input_data;
    logic         busy;
    logic         done;
    logic [9:0]   lines_written;
    logic [1:0]   state_dbg;

    stream_line_packer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_input_data (mem_input_data),
        .busy           (busy),
        .done           (done),
        .lines_written  (lines_written),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [511:0] exp_q[$];
    logic [8:0]   addr_q[$];

    logic [511:0] model_line;
    int           model_idx;
    logic [8:0]   model_addr;

    typedef struct {
        logic [8:0]  start_addr;
        int          n_words;
        int          max_gap;
        logic        rand_data;
        logic [31:0] base;
        logic [9:0]  exp_lines;
        logic [8:0]  exp_next_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks (called at posedge+1)
    task automatic start_session(input logic [8:0] addr);
        start      = 1'b1;
        start_addr = addr;
        model_addr = {addr[8:4], 4'b0000};
        model_line = '0;
        model_idx  = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 512'(busy), 512'(1));
        check("start_ready", 512'(in_ready), 512'(1));
        check("start_addr", 512'(mem_address), 512'(model_addr));
        check("start_count", 512'(lines_written), 512'(0));
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, input int max_gap);
        int  gap;
        int  n;
        logic accepted;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        model_line[model_idx*32 +: 32] = data;
        model_idx++;
        if (model_idx == 16 || last) begin
            exp_q.push_back(model_line);
            addr_q.push_back(model_addr);
            model_addr = model_addr + 9'd16;
            model_line = '0;
            model_idx  = 0;
        end
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            accepted = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!accepted) check("accept_timeout", 512'(0), 512'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last word was accepted (edge N + 1).
    task automatic finish_session(input logic [9:0] exp_lines, input logic [8:0] exp_next);
        check("write_strobe", 512'(mem_write_en), 512'(1));
        check("write_ready_low", 512'(in_ready), 512'(0));
        check("write_busy", 512'(busy), 512'(1));
        @(posedge clk); #1;
        check("done_pulse", 512'(done), 512'(1));
        check("done_strobe_off", 512'(mem_write_en), 512'(0));
        check("done_count", 512'(lines_written), 512'(exp_lines));
        @(posedge clk); #1;
        check("done_drop", 512'(done), 512'(0));
        check("idle_busy", 512'(busy), 512'(0));
        check("next_addr", 512'(mem_address), 512'(exp_next));
    endtask

    initial begin
        logic [511:0] ed;
        logic [8:0]   ea;

        vecs[0] = '{9'h040, 16, 0, 1'b0, 32'h1,   10'd1, 9'h050};
        vecs[1] = '{9'h000, 5,  0, 1'b0, 32'hA0,  10'd1, 9'h010};
        vecs[2] = '{9'h1F3, 20, 0, 1'b0, 32'h300, 10'd2, 9'h010};
        vecs[3] = '{9'h100, 32, 3, 1'b1, 32'h0,   10'd2, 9'h120};
        vecs[4] = '{9'h0A5, 17, 2, 1'b1, 32'h0,   10'd2, 9'h0C0};

        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        model_line = '0;
        model_idx  = 0;
        model_addr = '0;

        // scoreboard: compare each write strobe against the model's next line
        fork
            forever begin
                @(negedge clk);
                if (mem_write_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 512'(1), 512'(0));
                    end else begin
                        ed = exp_q.pop_front();
                        ea = addr_q.pop_front();
                        check("line_data", mem_input_data, ed);
                        check("line_addr", 512'(mem_address), 512'(ea));
                        check("strobe_ready_low", 512'(in_ready), 512'(0));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 512'(in_ready), 512'(0));
        check("rst_strobe", 512'(mem_write_en), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_addr", 512'(mem_address), 512'(0));
        check("rst_data", mem_input_data, 512'(0));
        check("rst_count", 512'(lines_written), 512'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // table-driven sessions
        for (int v = 0; v < 5; v++) begin
            start_session(vecs[v].start_addr);
            for (int i = 0; i < vecs[v].n_words; i++) begin
                send_word(vecs[v].rand_data ? $urandom : vecs[v].base + 32'(i),
                          i == vecs[v].n_words - 1, vecs[v].max_gap);
            end
            finish_session(vecs[v].exp_lines, vecs[v].exp_next_addr);
            repeat (2) @(posedge clk);
            #1;
        end

        // start together with in_valid in IDLE: the word must not be taken
        start      = 1'b1;
        start_addr = 9'h0C0;
        in_valid   = 1'b1;
        in_data    = 32'hDEADBEEF;
        in_last    = 1'b1;
        model_addr = 9'h0C0;
        model_line = '0;
        model_idx  = 0;
        check("idle_ready_low", 512'(in_ready), 512'(0));
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("idle_word_dropped", 512'(in_ready), 512'(1));
        send_word(32'h11, 1'b0, 0);
        send_word(32'h22, 1'b1, 0);
        finish_session(10'd1, 9'h0D0);

        // start pulsed during FILL is ignored
        start_session(9'h080);
        for (int i = 0; i < 4; i++) send_word(32'h500 + 32'(i), 1'b0, 0);
        start      = 1'b1;
        start_addr = 9'h1C0;
        @(posedge clk); #1;
        start = 1'b0;
        check("fill_start_addr", 512'(mem_address), 512'(9'h080));
        check("fill_start_count", 512'(lines_written), 512'(0));
        check("fill_start_ready", 512'(in_ready), 512'(1));
        for (int i = 4; i < 16; i++) send_word(32'h500 + 32'(i), i == 15, 1);
        finish_session(10'd1, 9'h090);

        // asynchronous reset after 7 words of a line
        start_session(9'h020);
        for (int i = 0; i < 7; i++) send_word(32'h700 + 32'(i), 1'b0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", 512'(in_ready), 512'(0));
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_addr", 512'(mem_address), 512'(0));
        check("midrst_data", mem_input_data, 512'(0));
        check("midrst_no_pending", 512'(exp_q.size()), 512'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_session(9'h060);
        for (int i = 0; i < 3; i++) send_word(32'hB00 + 32'(i), i == 2, 0);
        finish_session(10'd1, 9'h070);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drain", 512'(exp_q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/stream_line_packer.md
Name:
stream_line_packer

Overview:
Upstream feeder for the 512-word × 32-bit line memory. Accepts a serial stream of signed 32-bit words over a valid/ready handshake and packs 16 consecutive words into one 512-bit line. Writes each line with a single-cycle write strobe at a 16-word-aligned address that advances per line. A partial final line, marked by in_last, is flushed zero-padded.

Parameters:
WORD_W, 32, width of one stream word / memory word
LINE_WORDS, 16, words per memory line (burst length of memory port)
ADDR_W, 9, memory word-address width (512 words)
CNT_W, 10, width of lines_written counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a packing session (IDLE only)
start_addr  in  ADDR_W  first line word address; low 4 bits forced to 0
in_valid  in  1  stream word valid
in_ready  out  1  packer can accept a word
in_data  in  WORD_W  stream word
in_last  in  1  qualifies the final word of a session
mem_write_en  out  1  one-cycle line write strobe to memory
mem_address  out  ADDR_W  line base word address
mem_input_data  out  WORD_W*LINE_WORDS  packed line; word k at bits [k*32 +: 32]
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after final line written
lines_written  out  CNT_W  lines written in current session

Behaviour:
- Reset (async, rst=0): state=IDLE; in_ready, mem_write_en, busy, done = 0; mem_address, mem_input_data, lines_written, word index = 0. Takes effect immediately, including mid-FILL or mid-WRITE; a partially filled line is discarded and any in-progress write strobe drops at once.
- All outputs are registered, updated on posedge clk. The memory samples on negedge, so mem_write_en, mem_address and mem_input_data are stable for the whole write cycle.
- States:
  - IDLE: in_ready=0, busy=0.
    - On start: mem_address = start_addr with bits[3:0]=0; buffer cleared; word_idx=0; lines_written=0; go to FILL.
  - FILL: in_ready=1.
    - Accept occurs when in_valid & in_ready at posedge: buffer[word_idx] = in_data; word_idx+1.
    - If the accepted word has word_idx==15, or in_last=1: capture last_flag=in_last, go to WRITE, drop in_ready.
    - in_valid=0 cycles stall with no state change.
  - WRITE: mem_write_en=1 for exactly one cycle; in_ready=0. Unfilled slots of mem_input_data are 0.
    - At cycle end: mem_address += 16 (wraps mod 512, 496→0); lines_written+1 (wraps mod 2^CNT_W); buffer cleared; word_idx=0.
    - Next state is DONE if last_flag, else FILL.
  - DONE: done=1 for one cycle; busy=1; then IDLE. mem_address retains the next-line address.
- Latency: word 16 (or the in_last word) accepted at edge N → mem_write_en high during cycle N+1 → done high in cycle N+2 if last.
- Throughput: 16 words per 17 cycles.
- start outside IDLE is ignored. in_last on a 16th word produces a single full line, with no extra empty line.
- Simultaneous start and in_valid in IDLE: the word is not accepted (in_ready=0).
- Stream words are treated as raw bits; no sign or arithmetic processing.

Decomposition:
- Shared package: WORD_W, LINE_WORDS, ADDR_W constants; state enum {IDLE, FILL, WRITE, DONE}; LINE_W = WORD_W*LINE_WORDS; LINE_STRIDE = 16.
- Optional sub-module line_buffer: 16×32 register array with indexed write, synchronous clear, and flat 512-bit output. The FSM and address/count logic stay in the top.

Test Plan:
- Full line: start, start_addr=0x040; stream 0x1..0x10, last on word 16 → one strobe at address 0x040 with data[31:0]=0x1 and [511:480]=0x10; done 2 cycles after the last accept; lines_written=1; memory reads back the same line.
- Partial flush: start_addr=0x000; 5 words 0xA0..0xA4 with last on the 5th → strobe at 0x000, words 0–4 = 0xA0..0xA4, words 5–15 = 0.
- Wrap and misalignment: start_addr=0x1F3 → first line at 0x1F0; 20 words with last on the 20th → strobes at 0x1F0 (16 words), then 0x000 (4 words + zeros); lines_written=2.
- Backpressure and gaps: randomised in_valid gaps across 32 words → exactly 2 strobes; in_ready low during each WRITE cycle; no word lost or duplicated.
- Reset mid-FILL after 7 words: rst low → all outputs 0 immediately; no strobe; a new session after release writes only new data.
- start pulsed during FILL → ignored: mem_address and lines_written unchanged; session completes normally.
